pipeline_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage cached RV32I pipeline. It merges three hazard sources: load-use (one-cycle bubble), taken branch/jump (flush), and data-cache miss (multi-cycle refill FSM with optional dirty write-back). It drives per-stage enables and flushes plus the main-memory refill handshake. It sits beside the hazard/forwarding logic and replaces the standalone load-use stall.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 15 +
 rtl/pipeline_stall_ctrl_if.sv | 29 ++
 rtl/pipeline_stall_ctrl_hazard_detect.sv | 27 ++
 rtl/pipeline_stall_ctrl.sv | 128 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
//   stall_state_t : refill sequencer states (IDLE, WB, FILL, DONE)
//   RESULT_LOAD   : ResultSrcE encoding that marks a load in Execute
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB   = 2'd1,
      FILL = 2'd2,
      DONE = 2'd3
   } stall_state_t;

   localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Main-memory refill/write-back handshake between the stall sequencer and
// the memory.
//   mem_req  : controller -> memory, a beat is requested (held across beats)
//   mem_we   : controller -> memory, 1 = write-back beat, 0 = refill beat
//   mem_beat : controller -> memory, word index within the cache line
//   fill_we  : controller -> cache, write the returned word at mem_beat
//   mem_ack  : memory -> controller, one beat completed this cycle
// Handshake: a beat completes on every cycle where mem_req=1 and mem_ack=1.
// mem_req=1 with mem_ack=0 is a wait state; beat index and direction hold.
// The controller may drop mem_req (reset) with a beat outstanding.
interface pipeline_stall_ctrl_if #(
   parameter int BEAT_W = 2
);
   logic              mem_req;
   logic              mem_we;
   logic [BEAT_W-1:0] mem_beat;
   logic              fill_we;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_beat, fill_we,
      input  mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_beat, fill_we,
      output mem_ack
   );
endinterface

// File: rtl/pipeline_stall_ctrl_hazard_detect.sv
// Combinational hazard terms for the stall sequencer.
//   ResultSrcE, RdE : result select / destination of the instruction in Execute
//   Rs1D, Rs2D      : source registers of the instruction in Decode
//   PCSrcE          : taken branch/jump resolved in Execute
//   lw_stall        : load-use hazard (one-cycle bubble)
//   br_flush        : branch flush request
// The top-level sequencer overrides both while a cache miss is serviced.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [1:0] ResultSrcE,
   input  logic [4:0] RdE,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic       PCSrcE,
   output logic       lw_stall,
   output logic       br_flush
);

   always_comb begin
      // x0 is never a real dependency, so a load to x0 cannot stall.
      lw_stall = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                 ((RdE == Rs1D) || (RdE == Rs2D));
      br_flush = PCSrcE;
   end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the five-stage cached RV32I pipeline.
// Merges load-use stalls, branch flushes and data-cache miss refills.
//   clk, rst            : clock, synchronous active-high reset
//   ResultSrcE, RdE     : Execute-stage result select / destination
//   Rs1D, Rs2D          : Decode-stage source registers
//   PCSrcE              : taken branch/jump in Execute
//   DMissM, DDirtyM     : data-cache miss / dirty victim for the Memory access
//   FEN, DEN, EEN, MEN  : stage-register enables (1 = advance)
//   RSTD, RSTE, RSTW    : flush Decode / Execute / Writeback registers
//   mem                 : refill handshake (master side)
//   state_dbg           : current sequencer state
module pipeline_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int WORDS_PER_LINE = 4,
   parameter int BEAT_W         = $clog2(WORDS_PER_LINE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            ResultSrcE,
   input  logic [4:0]            RdE,
   input  logic [4:0]            Rs1D,
   input  logic [4:0]            Rs2D,
   input  logic                  PCSrcE,
   input  logic                  DMissM,
   input  logic                  DDirtyM,
   output logic                  FEN,
   output logic                  DEN,
   output logic                  EEN,
   output logic                  MEN,
   output logic                  RSTD,
   output logic                  RSTE,
   output logic                  RSTW,
   pipeline_stall_ctrl_if.master mem,
   output stall_state_t          state_dbg
);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

   stall_state_t      state_q, state_d, state_eff;
   logic [BEAT_W-1:0] cnt_q, cnt_d, cnt_eff;
   logic              lw_stall, br_flush;
   logic              miss_stall;

   hazard_detect u_hazard (
      .ResultSrcE (ResultSrcE),
      .RdE        (RdE),
      .Rs1D       (Rs1D),
      .Rs2D       (Rs2D),
      .PCSrcE     (PCSrcE),
      .lw_stall   (lw_stall),
      .br_flush   (br_flush)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      // While reset is held the outputs already look like IDLE with beat 0,
      // so an abandoned refill stops requesting memory immediately.
      state_eff    = rst ? IDLE : state_q;
      cnt_eff      = rst ? '0 : cnt_q;
      state_d      = state_eff;
      cnt_d        = cnt_eff;
      mem.mem_req  = 1'b0;
      mem.mem_we   = 1'b0;
      mem.fill_we  = 1'b0;
      mem.mem_beat = cnt_eff;

      case (state_eff)
         IDLE: begin
            if (DMissM) state_d = DDirtyM ? WB : FILL;
         end
         WB: begin
            mem.mem_req = 1'b1;
            mem.mem_we  = 1'b1;
            if (mem.mem_ack) begin
               cnt_d = cnt_eff + BEAT_W'(1);
               if (cnt_eff == LAST_BEAT) state_d = FILL;
            end
         end
         FILL: begin
            mem.mem_req = 1'b1;
            mem.fill_we = mem.mem_ack;
            if (mem.mem_ack) begin
               cnt_d = cnt_eff + BEAT_W'(1);
               if (cnt_eff == LAST_BEAT) state_d = DONE;
            end
         end
         DONE: begin
            // One extra held cycle lets the cache re-look-up the refilled line.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A miss freezes the whole pipe and bubbles Writeback; load-use and
      // branch terms are ignored until release and re-evaluated then.
      miss_stall = (state_eff != IDLE) || DMissM;
      if (miss_stall) begin
         FEN  = 1'b0;
         DEN  = 1'b0;
         EEN  = 1'b0;
         MEN  = 1'b0;
         RSTD = 1'b0;
         RSTE = 1'b0;
         RSTW = 1'b1;
      end else begin
         FEN  = ~lw_stall;
         DEN  = ~lw_stall;
         EEN  = 1'b1;
         MEN  = 1'b1;
         RSTD = br_flush;
         RSTE = lw_stall | br_flush;
         RSTW = 1'b0;
      end

      state_dbg = state_eff;
   end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int WPL    = 4;
   localparam int BEAT_W = 2;

   // {FEN,DEN,EEN,MEN,RSTD,RSTE,RSTW}
   localparam logic [6:0] ST_RUN    = 7'b1111_000;
   localparam logic [6:0] ST_LW     = 7'b0011_010;
   localparam logic [6:0] ST_BR     = 7'b1111_110;
   localparam logic [6:0] ST_LW_BR  = 7'b0011_110;
   localparam logic [6:0] ST_MISS   = 7'b0000_001;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] ResultSrcE;
   logic [4:0] RdE, Rs1D, Rs2D;
   logic       PCSrcE, DMissM, DDirtyM;
   logic       FEN, DEN, EEN, MEN, RSTD, RSTE, RSTW;
   stall_state_t state_dbg;

   int checks = 0;
   int errors = 0;
   int stall_cycles = 0;
   int base;

   pipeline_stall_ctrl_if #(.BEAT_W(BEAT_W)) mif ();

   pipeline_stall_ctrl #(.WORDS_PER_LINE(WPL)) dut (
      .clk        (clk),
      .rst        (rst),
      .ResultSrcE (ResultSrcE),
      .RdE        (RdE),
      .Rs1D       (Rs1D),
      .Rs2D       (Rs2D),
      .PCSrcE     (PCSrcE),
      .DMissM     (DMissM),
      .DDirtyM    (DDirtyM),
      .FEN        (FEN),
      .DEN        (DEN),
      .EEN        (EEN),
      .MEN        (MEN),
      .RSTD       (RSTD),
      .RSTE       (RSTE),
      .RSTW       (RSTW),
      .mem        (mif.master),
      .state_dbg  (state_dbg)
   );

   // clock/reset block
   always #5 clk = ~clk;

   logic [6:0] stage_obs;
   logic [4:0] mem_obs;   // {mem_req, mem_we, fill_we, mem_beat}
   assign stage_obs = {FEN, DEN, EEN, MEN, RSTD, RSTE, RSTW};
   assign mem_obs   = {mif.mem_req, mif.mem_we, mif.fill_we, mif.mem_beat};

   always @(negedge clk) if (!rst && RSTW) stall_cycles++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_hz(input logic [1:0] rs, input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic br);
      ResultSrcE = rs; RdE = rd; Rs1D = r1; Rs2D = r2; PCSrcE = br;
   endtask

   task automatic chk_cycle(input string tag, input logic [6:0] st, input logic [4:0] mm,
                            input logic [1:0] s);
      #1;
      check({tag, "_stage"}, 32'(stage_obs), 32'(st));
      check({tag, "_mem"},   32'(mem_obs),   32'(mm));
      check({tag, "_state"}, 32'(state_dbg), 32'(s));
   endtask

   initial begin
      logic [1:0] bb;
      rst = 1'b1; DMissM = 1'b0; DDirtyM = 1'b0; mif.mem_ack = 1'b0;
      set_hz(2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
      chk_cycle("in_reset", ST_RUN, 5'b00000, IDLE);
      tick();
      rst = 1'b0;
      tick();
      chk_cycle("after_reset", ST_RUN, 5'b00000, IDLE);

      // load-use on Rs1, then bubble inserted upstream clears the hazard
      set_hz(2'b01, 5'd5, 5'd5, 5'd9, 1'b0);
      chk_cycle("lw_rs1", ST_LW, 5'b00000, IDLE);
      tick();
      set_hz(2'b00, 5'd0, 5'd5, 5'd9, 1'b0);
      chk_cycle("lw_release", ST_RUN, 5'b00000, IDLE);
      tick();
      set_hz(2'b01, 5'd7, 5'd1, 5'd7, 1'b0);
      chk_cycle("lw_rs2", ST_LW, 5'b00000, IDLE);
      tick();
      set_hz(2'b01, 5'd0, 5'd0, 5'd0, 1'b0);
      chk_cycle("lw_x0", ST_RUN, 5'b00000, IDLE);
      tick();
      set_hz(2'b10, 5'd5, 5'd5, 5'd5, 1'b0);
      chk_cycle("non_load", ST_RUN, 5'b00000, IDLE);
      tick();
      set_hz(2'b00, 5'd0, 5'd0, 5'd0, 1'b1);
      chk_cycle("branch", ST_BR, 5'b00000, IDLE);
      tick();
      set_hz(2'b01, 5'd5, 5'd5, 5'd0, 1'b1);
      chk_cycle("lw_branch", ST_LW_BR, 5'b00000, IDLE);
      tick();

      // clean miss, ack every cycle
      set_hz(2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
      DMissM = 1'b1; DDirtyM = 1'b0; mif.mem_ack = 1'b1;
      base = stall_cycles;
      chk_cycle("clean_idle", ST_MISS, 5'b00000, IDLE);
      for (int b = 0; b < WPL; b++) begin
         tick();
         bb = b[1:0];
         chk_cycle($sformatf("clean_fill%0d", b), ST_MISS, {3'b101, bb}, FILL);
      end
      tick();
      DMissM = 1'b0; mif.mem_ack = 1'b0;
      chk_cycle("clean_done", ST_MISS, 5'b00000, DONE);
      tick();
      chk_cycle("clean_release", ST_RUN, 5'b00000, IDLE);
      check("clean_stall_len", 32'(stall_cycles - base), 32'd6);

      // dirty miss, ack on alternate cycles
      DMissM = 1'b1; DDirtyM = 1'b1; mif.mem_ack = 1'b0;
      base = stall_cycles;
      chk_cycle("dirty_idle", ST_MISS, 5'b00000, IDLE);
      for (int b = 0; b < WPL; b++) begin
         bb = b[1:0];
         tick(); mif.mem_ack = 1'b0;
         chk_cycle($sformatf("wb%0d_wait", b), ST_MISS, {3'b110, bb}, WB);
         tick(); mif.mem_ack = 1'b1;
         chk_cycle($sformatf("wb%0d_ack", b), ST_MISS, {3'b110, bb}, WB);
      end
      for (int b = 0; b < WPL; b++) begin
         bb = b[1:0];
         tick(); mif.mem_ack = 1'b0;
         chk_cycle($sformatf("fill%0d_wait", b), ST_MISS, {3'b100, bb}, FILL);
         tick(); mif.mem_ack = 1'b1;
         chk_cycle($sformatf("fill%0d_ack", b), ST_MISS, {3'b101, bb}, FILL);
      end
      tick();
      DMissM = 1'b0; DDirtyM = 1'b0; mif.mem_ack = 1'b0;
      chk_cycle("dirty_done", ST_MISS, 5'b00000, DONE);
      tick();
      chk_cycle("dirty_release", ST_RUN, 5'b00000, IDLE);
      check("dirty_stall_len", 32'(stall_cycles - base), 32'd18);

      // reset in the middle of a refill
      DMissM = 1'b1; mif.mem_ack = 1'b1;
      tick();
      tick();
      tick();
      chk_cycle("pre_reset_beat2", ST_MISS, 5'b10110, FILL);
      rst = 1'b1; DMissM = 1'b0; mif.mem_ack = 1'b0;
      tick();
      rst = 1'b0;
      chk_cycle("mid_reset", ST_RUN, 5'b00000, IDLE);
      tick();
      DMissM = 1'b1; mif.mem_ack = 1'b0;
      chk_cycle("remiss_idle", ST_MISS, 5'b00000, IDLE);
      tick();
      chk_cycle("remiss_beat0", ST_MISS, 5'b10000, FILL);
      rst = 1'b1; DMissM = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      // miss coincident with branch and load-use
      set_hz(2'b01, 5'd5, 5'd5, 5'd0, 1'b1);
      DMissM = 1'b1; DDirtyM = 1'b0; mif.mem_ack = 1'b1;
      chk_cycle("combo_idle", ST_MISS, 5'b00000, IDLE);
      for (int b = 0; b < WPL; b++) begin
         tick();
         bb = b[1:0];
         chk_cycle($sformatf("combo_fill%0d", b), ST_MISS, {3'b101, bb}, FILL);
      end
      tick();
      DMissM = 1'b0; mif.mem_ack = 1'b0;
      chk_cycle("combo_done", ST_MISS, 5'b00000, DONE);
      tick();
      chk_cycle("combo_release", ST_LW_BR, 5'b00000, IDLE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
